// File: rtl/vga_timgen.sv
// VGA/LCD timing generator: pixel-tick divider, H/V phase FSMs with frame-boundary shadowing of all timing fields.
// Timing outputs registered one clock after the state they reflect; free-running, no backpressure.
module vga_timgen #(
    parameter int TB_WIDTH  = 10,
    parameter int VB_WIDTH  = 16,
    parameter int CNT_WIDTH = 12,
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic [VB_WIDTH-1:0]  hvlen_i,
    input  logic [VB_WIDTH-1:0]  vvlen_i,
    input  logic [TB_WIDTH-1:0]  hfp_i,
    input  logic [TB_WIDTH-1:0]  hsn_i,
    input  logic [TB_WIDTH-1:0]  hbp_i,
    input  logic [TB_WIDTH-1:0]  vfp_i,
    input  logic [TB_WIDTH-1:0]  vsn_i,
    input  logic [TB_WIDTH-1:0]  vbp_i,
    input  logic                 hspol_i,
    input  logic                 vspol_i,
    input  logic                 blpol_i,
    output logic                 pix_tick_o,
    output logic                 hsync_o,
    output logic                 vsync_o,
    output logic                 blank_o,
    output logic                 de_o,
    output logic [CNT_WIDTH-1:0] hcnt_o,
    output logic [CNT_WIDTH-1:0] vcnt_o,
    output logic                 hint_o,
    output logic                 vint_o,
    output logic                 fb_swap_o
);

    typedef enum logic [1:0] {
        ST_BP   = 2'b00,
        ST_VIS  = 2'b01,
        ST_FP   = 2'b10,
        ST_SYNC = 2'b11
    } phase_e;

    logic                 en_q, en_d;
    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    phase_e               hst_q, hst_d, vst_q, vst_d;
    logic [CNT_WIDTH-1:0] hpc_q, hpc_d, vpc_q, vpc_d;

    logic [DIV_WIDTH-1:0] div_s_q, div_s_d;
    logic [CNT_WIDTH-1:0] hvlen_s_q, hvlen_s_d, vvlen_s_q, vvlen_s_d;
    logic [TB_WIDTH-1:0]  hfp_s_q, hfp_s_d, hsn_s_q, hsn_s_d, hbp_s_q, hbp_s_d;
    logic [TB_WIDTH-1:0]  vfp_s_q, vfp_s_d, vsn_s_q, vsn_s_d, vbp_s_q, vbp_s_d;
    logic                 hspol_s_q, hspol_s_d, vspol_s_q, vspol_s_d, blpol_s_q, blpol_s_d;

    logic                 hsync_q, hsync_d, vsync_q, vsync_d, blank_q, blank_d, de_q, de_d;
    logic [CNT_WIDTH-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic                 hint_q, hint_d, vint_q, vint_d, swap_q, swap_d;

    logic                 tick, h_last, v_last, line_start, frame_end, de_c;
    logic [CNT_WIDTH-1:0] h_end, v_end;

    always_comb begin
        en_d      = en_i;
        div_cnt_d = div_cnt_q;
        hst_d     = hst_q;
        hpc_d     = hpc_q;
        vst_d     = vst_q;
        vpc_d     = vpc_q;
        div_s_d   = div_s_q;
        hvlen_s_d = hvlen_s_q;
        vvlen_s_d = vvlen_s_q;
        hfp_s_d   = hfp_s_q;
        hsn_s_d   = hsn_s_q;
        hbp_s_d   = hbp_s_q;
        vfp_s_d   = vfp_s_q;
        vsn_s_d   = vsn_s_q;
        vbp_s_d   = vbp_s_q;
        hspol_s_d = hspol_s_q;
        vspol_s_d = vspol_s_q;
        blpol_s_d = blpol_s_q;

        tick = en_i && (div_cnt_q == div_s_q);

        case (hst_q)
            ST_BP:   h_end = CNT_WIDTH'(hbp_s_q);
            ST_VIS:  h_end = hvlen_s_q;
            ST_FP:   h_end = CNT_WIDTH'(hfp_s_q);
            default: h_end = CNT_WIDTH'(hsn_s_q);
        endcase
        case (vst_q)
            ST_BP:   v_end = CNT_WIDTH'(vbp_s_q);
            ST_VIS:  v_end = vvlen_s_q;
            ST_FP:   v_end = CNT_WIDTH'(vfp_s_q);
            default: v_end = CNT_WIDTH'(vsn_s_q);
        endcase

        h_last     = (hpc_q == h_end);
        v_last     = (vpc_q == v_end);
        line_start = tick && h_last && (hst_q == ST_BP);
        frame_end  = line_start && v_last && (vst_q == ST_BP);

        if (!en_i) begin
            div_cnt_d = '0;
            hst_d     = ST_SYNC;
            hpc_d     = '0;
            vst_d     = ST_SYNC;
            vpc_d     = '0;
        end else begin
            div_cnt_d = tick ? '0 : div_cnt_q + DIV_WIDTH'(1);
            if (tick) begin
                hst_d = h_last ? phase_e'(hst_q + 2'd1) : hst_q;
                hpc_d = h_last ? '0 : hpc_q + CNT_WIDTH'(1);
            end
            if (line_start) begin
                vst_d = v_last ? phase_e'(vst_q + 2'd1) : vst_q;
                vpc_d = v_last ? '0 : vpc_q + CNT_WIDTH'(1);
            end
        end

        // The current tick already used the old shadows above; new values take effect next clock.
        if ((en_i && !en_q) || frame_end) begin
            div_s_d   = div_i;
            hvlen_s_d = CNT_WIDTH'(hvlen_i);
            vvlen_s_d = CNT_WIDTH'(vvlen_i);
            hfp_s_d   = hfp_i;
            hsn_s_d   = hsn_i;
            hbp_s_d   = hbp_i;
            vfp_s_d   = vfp_i;
            vsn_s_d   = vsn_i;
            vbp_s_d   = vbp_i;
            hspol_s_d = hspol_i;
            vspol_s_d = vspol_i;
            blpol_s_d = blpol_i;
        end

        de_c    = en_i && (hst_q == ST_VIS) && (vst_q == ST_VIS);
        de_d    = de_c;
        blank_d = ~de_c ^ blpol_s_q;
        hsync_d = (en_i && (hst_q == ST_SYNC)) ^ hspol_s_q;
        vsync_d = (en_i && (vst_q == ST_SYNC)) ^ vspol_s_q;
        hcnt_d  = (en_i && (hst_q == ST_VIS)) ? hpc_q : '0;
        vcnt_d  = (en_i && (vst_q == ST_VIS)) ? vpc_q : '0;
        hint_d  = tick && h_last && (hst_q == ST_FP);
        vint_d  = line_start && v_last && (vst_q == ST_FP);
        swap_d  = vint_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            en_q      <= 1'b0;
            div_cnt_q <= '0;
            hst_q     <= ST_SYNC;
            hpc_q     <= '0;
            vst_q     <= ST_SYNC;
            vpc_q     <= '0;
            div_s_q   <= '0;
            hvlen_s_q <= '0;
            vvlen_s_q <= '0;
            hfp_s_q   <= '0;
            hsn_s_q   <= '0;
            hbp_s_q   <= '0;
            vfp_s_q   <= '0;
            vsn_s_q   <= '0;
            vbp_s_q   <= '0;
            hspol_s_q <= 1'b0;
            vspol_s_q <= 1'b0;
            blpol_s_q <= 1'b0;
            hsync_q   <= 1'b0;
            vsync_q   <= 1'b0;
            blank_q   <= 1'b1;
            de_q      <= 1'b0;
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            hint_q    <= 1'b0;
            vint_q    <= 1'b0;
            swap_q    <= 1'b0;
        end else begin
            en_q      <= en_d;
            div_cnt_q <= div_cnt_d;
            hst_q     <= hst_d;
            hpc_q     <= hpc_d;
            vst_q     <= vst_d;
            vpc_q     <= vpc_d;
            div_s_q   <= div_s_d;
            hvlen_s_q <= hvlen_s_d;
            vvlen_s_q <= vvlen_s_d;
            hfp_s_q   <= hfp_s_d;
            hsn_s_q   <= hsn_s_d;
            hbp_s_q   <= hbp_s_d;
            vfp_s_q   <= vfp_s_d;
            vsn_s_q   <= vsn_s_d;
            vbp_s_q   <= vbp_s_d;
            hspol_s_q <= hspol_s_d;
            vspol_s_q <= vspol_s_d;
            blpol_s_q <= blpol_s_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            blank_q   <= blank_d;
            de_q      <= de_d;
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            hint_q    <= hint_d;
            vint_q    <= vint_d;
            swap_q    <= swap_d;
        end
    end

    assign pix_tick_o = tick;
    assign hsync_o    = hsync_q;
    assign vsync_o    = vsync_q;
    assign blank_o    = blank_q;
    assign de_o       = de_q;
    assign hcnt_o     = hcnt_q;
    assign vcnt_o     = vcnt_q;
    assign hint_o     = hint_q;
    assign vint_o     = vint_q;
    assign fb_swap_o  = swap_q;

endmodule

// File: tb/tb_vga_timgen.sv
// Directed bench for vga_timgen: frame-by-frame measurements between vint pulses against hand-computed counts.
module tb_vga_timgen;

    localparam int TBW = 10;
    localparam int VBW = 16;
    localparam int CW  = 12;
    localparam int DW  = 8;

    logic           clk_i = 1'b0;
    logic           rst_n_i, en_i;
    logic [DW-1:0]  div_i;
    logic [VBW-1:0] hvlen_i, vvlen_i;
    logic [TBW-1:0] hfp_i, hsn_i, hbp_i, vfp_i, vsn_i, vbp_i;
    logic           hspol_i, vspol_i, blpol_i;
    logic           pix_tick_o, hsync_o, vsync_o, blank_o, de_o;
    logic [CW-1:0]  hcnt_o, vcnt_o;
    logic           hint_o, vint_o, fb_swap_o;

    always #5 clk_i = ~clk_i;

    vga_timgen #(.TB_WIDTH(TBW), .VB_WIDTH(VBW), .CNT_WIDTH(CW), .DIV_WIDTH(DW)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .div_i(div_i),
        .hvlen_i(hvlen_i), .vvlen_i(vvlen_i),
        .hfp_i(hfp_i), .hsn_i(hsn_i), .hbp_i(hbp_i),
        .vfp_i(vfp_i), .vsn_i(vsn_i), .vbp_i(vbp_i),
        .hspol_i(hspol_i), .vspol_i(vspol_i), .blpol_i(blpol_i),
        .pix_tick_o(pix_tick_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
        .blank_o(blank_o), .de_o(de_o), .hcnt_o(hcnt_o), .vcnt_o(vcnt_o),
        .hint_o(hint_o), .vint_o(vint_o), .fb_swap_o(fb_swap_o)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expectations for the visible-line contents of the next measured frame.
    int             div_e = 0;
    int             hv_e  = 4;
    logic           pol_e = 1'b0;
    int             chg_at = 0;
    logic [VBW-1:0] chg_val = '0;

    int fr_n, fr_ticks, fr_hs, fr_vs, fr_de, fr_hint, fr_seqbad, fr_blankbad, fr_swapbad, fr_lagbad;

    task automatic wait_vint();
        bit seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk_i);
            if (vint_o) seen = 1'b1;
        end
        if (!seen) chk("vint_wait_timeout", 0, 1);
    endtask

    // Called on the sample where vint_o is high; measures through the next vint_o sample.
    task automatic run_frame();
        logic [2*CW+3:0] prev, cur;
        logic            t1, t2;
        int              k;
        bit              done;
        fr_n = 0; fr_ticks = 0; fr_hs = 0; fr_vs = 0; fr_de = 0; fr_hint = 0;
        fr_seqbad = 0; fr_blankbad = 0; fr_swapbad = 0; fr_lagbad = 0;
        prev = {hsync_o, vsync_o, blank_o, de_o, hcnt_o, vcnt_o};
        t1 = pix_tick_o;
        t2 = 1'b1;
        k = 0;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk_i);
            fr_n++;
            if (fr_n == chg_at) hvlen_i = chg_val;
            cur = {hsync_o, vsync_o, blank_o, de_o, hcnt_o, vcnt_o};
            if (fr_n >= 2 && cur !== prev && !t2) fr_lagbad++;
            t2 = t1;
            t1 = pix_tick_o;
            prev = cur;
            fr_ticks += int'(pix_tick_o);
            fr_hs    += int'(hsync_o != pol_e);
            fr_vs    += int'(vsync_o != pol_e);
            fr_de    += int'(de_o);
            fr_hint  += int'(hint_o);
            if (de_o) begin
                if (int'(hcnt_o) != (k / (div_e + 1)) % hv_e) fr_seqbad++;
                if (int'(vcnt_o) != k / ((div_e + 1) * hv_e)) fr_seqbad++;
                k++;
            end
            if (blank_o !== (~de_o ^ pol_e)) fr_blankbad++;
            if (fb_swap_o !== vint_o) fr_swapbad++;
            if (vint_o) done = 1'b1;
        end
        if (!done) chk("frame_timeout", 0, 1);
    endtask

    int hs_run, vint_at;

    initial begin
        rst_n_i = 1'b0; en_i = 1'b0; div_i = '0;
        hvlen_i = 16'd3; vvlen_i = 16'd1;
        hfp_i = 10'd1; hsn_i = 10'd1; hbp_i = 10'd1;
        vfp_i = '0; vsn_i = '0; vbp_i = '0;
        hspol_i = 1'b0; vspol_i = 1'b0; blpol_i = 1'b0;

        repeat (5) @(negedge clk_i);
        chk("rst_hsync", hsync_o, 0);
        chk("rst_vsync", vsync_o, 0);
        chk("rst_blank", blank_o, 1);
        chk("rst_de", de_o, 0);
        chk("rst_tick", pix_tick_o, 0);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        chk("dis_blank", blank_o, 1);

        // Baseline: 10-clock lines, 5-line frames, div 0.
        en_i = 1'b1;
        wait_vint();
        run_frame();
        chk("f0_len", fr_n, 50);
        chk("f0_ticks", fr_ticks, 50);
        chk("f0_hsync", fr_hs, 10);
        chk("f0_vsync", fr_vs, 10);
        chk("f0_de", fr_de, 8);
        chk("f0_hint", fr_hint, 5);
        chk("f0_seq", fr_seqbad, 0);
        chk("f0_blank", fr_blankbad, 0);
        chk("f0_swap", fr_swapbad, 0);

        // hvlen 3 -> 5 during a visible line: current frame keeps old timing.
        chg_at = 25; chg_val = 16'd5;
        run_frame();
        chg_at = 0;
        chk("hv_cur_len", fr_n, 50);
        chk("hv_cur_de", fr_de, 8);
        hv_e = 6;
        run_frame();
        chk("hv_mix_len", fr_n, 56);
        chk("hv_mix_de", fr_de, 12);
        chk("hv_mix_seq", fr_seqbad, 0);
        run_frame();
        chk("hv_new_len", fr_n, 60);
        chk("hv_new_de", fr_de, 12);
        chk("hv_new_hsync", fr_hs, 10);
        hvlen_i = 16'd3; hv_e = 4;
        run_frame();
        chk("hv_back_len", fr_n, 54);
        run_frame();
        chk("hv_base_len", fr_n, 50);

        // Divider 2: tick every third clock.
        div_i = 8'd2; div_e = 2;
        run_frame();
        chk("div_mix_len", fr_n, 110);
        chk("div_mix_de", fr_de, 24);
        run_frame();
        chk("div_len", fr_n, 150);
        chk("div_ticks", fr_ticks, 50);
        chk("div_hsync", fr_hs, 30);
        chk("div_vsync", fr_vs, 30);
        chk("div_de", fr_de, 24);
        chk("div_hint", fr_hint, 5);
        chk("div_seq", fr_seqbad, 0);
        chk("div_lag", fr_lagbad, 0);
        chk("div_swap", fr_swapbad, 0);
        div_i = '0; div_e = 0;
        run_frame();
        chk("div_back_len", fr_n, 90);
        run_frame();
        chk("div_base_len", fr_n, 50);

        // Disable during a visible pixel, restart three clocks later.
        repeat (21) @(negedge clk_i);
        chk("pre_dis_de", de_o, 1);
        @(negedge clk_i);
        chk("pre_dis_hcnt", hcnt_o, 1);
        en_i = 1'b0;
        #1;
        chk("dis_tick", pix_tick_o, 0);
        @(negedge clk_i);
        chk("dis_de", de_o, 0);
        chk("dis_hcnt", hcnt_o, 0);
        chk("dis_blank_inact", blank_o, 1);
        chk("dis_hsync_inact", hsync_o, 0);
        repeat (2) @(negedge clk_i);
        en_i = 1'b1;
        hs_run = 0; vint_at = 0;
        for (int j = 1; j <= 200 && vint_at == 0; j++) begin
            @(negedge clk_i);
            if (j == 1) begin
                chk("rst_sync_h", hsync_o, 1);
                chk("rst_sync_v", vsync_o, 1);
            end
            if (j <= 4) hs_run += int'(hsync_o);
            if (vint_o) vint_at = j;
        end
        chk("restart_hsync_len", hs_run, 2);
        chk("restart_vint_at", vint_at, 44);

        // All polarities inverted.
        hspol_i = 1'b1; vspol_i = 1'b1; blpol_i = 1'b1;
        run_frame();
        pol_e = 1'b1;
        run_frame();
        chk("pol_len", fr_n, 50);
        chk("pol_hsync_low", fr_hs, 10);
        chk("pol_vsync_low", fr_vs, 10);
        chk("pol_de", fr_de, 8);
        chk("pol_blank_eq_de", fr_blankbad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
